mskand_hpc2_array: RTL
======================

MSKAND_HPC2_ARRAY -- requirements
Module: mskand_hpc2_array

Interface
REQ-001 The block SHALL have parameter d, default 2, meaning number of shares (d >= 2).
REQ-002 The block SHALL have parameter N, default 8, meaning number of parallel bit lanes.
REQ-003 The block SHALL have local constant RNDW = N*d*(d-1)/2, meaning randomness bits consumed per operation.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 nrst  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  operation start; qualifies op_x, rnd and swap in cycle t.
REQ-007 swap  input  1  operand-role select, sampled with in_valid.
REQ-008 op_x  input  d*N  first operand sharing, presented in cycle t.
REQ-009 op_y  input  d*N  second operand sharing, presented in cycle t+1.
REQ-010 op_x_prev  input  d*N  op_x sharing re-presented in cycle t+1.
REQ-011 rnd  input  RNDW  fresh randomness, cycle t.
REQ-012 out  output  d*N  product sharing, valid in cycle t+2.
REQ-013 out_valid  output  1  qualifies out.
REQ-014 busy  output  1  high while any operation is in flight.

Function
REQ-015 The sharing layout SHALL be share-major: share i of lane j at bit i*N+j; lanes SHALL be fully independent.
REQ-016 Each lane SHALL implement an order-(d-1) HPC2 masked AND; unmasked out lane j SHALL equal (XOR of op_x lane j shares) AND (XOR of op_y lane j shares).
REQ-017 rnd SHALL be partitioned per lane, d*(d-1)/2 bits each; lane j SHALL use bits [j*d*(d-1)/2 +: d*(d-1)/2].
REQ-018 With swap=0: the latency-0 HPC2 port SHALL take op_x, the latency-1 port SHALL take op_y, and the latency-1 prev port SHALL take op_x_prev.
REQ-019 With swap=1: the latency-0 port SHALL take op_y, the latency-1 port SHALL take op_x_prev, and the prev port SHALL take op_y as captured in cycle t (provided the caller presents op_y in cycle t and again in cycle t+1).
REQ-020 swap SHALL be registered with in_valid; the cycle-t+1 input mux SHALL use the registered value, never the live input.
REQ-021 Latency SHALL be exactly 2 cycles: in_valid at t -> out_valid=1 at t+2 for one cycle.
REQ-022 Throughput SHALL be one operation per cycle; back-to-back in_valid SHALL produce back-to-back out_valid with no interference.
REQ-023 The valid pipeline SHALL be a 2-stage shift register (v1, v2); out_valid=v2; busy=v1 OR v2.
REQ-024 No output or internal path SHALL combine shares of the same lane combinationally before a register stage, except as required by HPC2.
REQ-025 When in_valid=0, input data SHALL be ignored; internal share registers MAY update but out_valid SHALL stay 0 for that slot.

Reset
REQ-026 nrst=0 SHALL immediately clear v1, v2, the registered swap and all internal share registers to 0.
REQ-027 During and after reset: out_valid=0, busy=0, out=0 until the first valid operation completes.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight operations; no out_valid SHALL appear for them after release.
REQ-029 The first in_valid accepted SHALL be in the first rising edge with nrst=1.

Configuration
REQ-030 Macro MSKAND_HPC2_ARRAY_OUT_GATE_EN: when defined, out SHALL be forced to all-zero in every cycle where out_valid=0; when undefined, out SHALL expose the output register contents unconditionally, and behaviour when out_valid=1 SHALL be identical in both builds.

Verification
REQ-031 d=2,N=8, swap=0, x=0xA5, y=0x3C with random masks -> unmasked out=0x24, out_valid at t+2 only.
REQ-032 Same values with swap=1 (op_y in t and t+1, op_x_prev=x in t+1) -> unmasked out=0x24.
REQ-033 Four back-to-back ops (0xFF&0x0F, 0xAA&0x55, 0x00&0xFF, 0xF0&0xF0) with alternating swap -> out 0x0F,0x00,0x00,0xF0 in consecutive cycles.
REQ-034 nrst pulsed low at t+1 of an op -> out_valid never asserts for it; busy=0 and out=0 immediately.
REQ-035 d=3,N=4, 1000 random ops with random rnd -> all unmasked products correct; each share individually uniform across masks.
REQ-036 With MSKAND_HPC2_ARRAY_OUT_GATE_EN defined, idle cycles after op -> out=0; undefined -> out holds last register value.

Source files
------------

// File: rtl/mskand_hpc2_array.sv
// mskand_hpc2_array
// N independent bit lanes, each an order-(d-1) HPC2 masked AND gadget.
// Sharings are share-major: share i of lane j sits at bit i*N+j.
// Latency is 2 cycles and throughput is one operation per cycle.
//
// Ports
//   clk        rising-edge clock
//   nrst       asynchronous active-low reset
//   in_valid   operation start in cycle t; qualifies op_x, rnd and swap
//   swap       operand-role select, sampled with in_valid
//   op_x       first operand sharing (cycle t)
//   op_y       second operand sharing (cycle t+1; also cycle t when swap=1)
//   op_x_prev  op_x sharing re-presented in cycle t+1
//   rnd        RNDW fresh random bits (cycle t), d*(d-1)/2 per lane
//   out        product sharing, valid in cycle t+2
//   out_valid  qualifies out
//   busy       an operation is in flight
//
// Build option
//   MSKAND_HPC2_ARRAY_OUT_GATE_EN: when defined, out reads zero in every
//   cycle where out_valid is low; otherwise out always shows the registers.
module mskand_hpc2_array #(
    parameter  int d    = 2,
    parameter  int N    = 8,
    localparam int RNDW = N*d*(d-1)/2
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            in_valid,
    input  logic            swap,
    input  logic [d*N-1:0]  op_x,
    input  logic [d*N-1:0]  op_y,
    input  logic [d*N-1:0]  op_x_prev,
    input  logic [RNDW-1:0] rnd,
    output logic [d*N-1:0]  out,
    output logic            out_valid,
    output logic            busy
);

    localparam int P = d*(d-1)/2;   // random bits per lane
    localparam int Q = d*(d-1);     // ordered share pairs (i,k), i != k

    // Index of the random bit shared by the unordered pair {i,k}.
    function automatic int pidx(input int i, input int k);
        int lo;
        int hi;
        lo = (i < k) ? i : k;
        hi = (i < k) ? k : i;
        return lo*d - (lo*(lo+1))/2 + (hi - lo - 1);
    endfunction

    // Dense index of the ordered pair (i,k), i != k.
    function automatic int oidx(input int i, input int k);
        return i*(d-1) + ((k < i) ? k : k - 1);
    endfunction

    logic              v1_q, v2_q, swap_q;
    logic [d*N-1:0]    b_q, b_d;
    logic [RNDW-1:0]   r_q;
    logic [Q*N-1:0]    u_q, u_d;
    logic [d*N-1:0]    ab_q, ab_d;
    logic [Q*N-1:0]    t1_q, t1_d, t2_q, t2_d;
    logic [d*N-1:0]    lat1, prv, res;

    // Stage 1: latency-0 operand masked with the pair randomness
    always_comb begin
        b_d = swap ? op_y : op_x;
        u_d = '0;
        for (int j = 0; j < N; j++) begin
            for (int i = 0; i < d; i++) begin
                for (int k = 0; k < d; k++) begin
                    if (k != i) begin
                        u_d[oidx(i,k)*N+j] = b_d[k*N+j] ^ rnd[j*P+pidx(i,k)];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            swap_q <= 1'b0;
            b_q    <= '0;
            r_q    <= '0;
            u_q    <= '0;
        end else begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            if (in_valid) begin
                swap_q <= swap;
                b_q    <= b_d;
                r_q    <= rnd;
                u_q    <= u_d;
            end
        end
    end

    // Stage 2: partial products, each kept in its own register so no
    // glitch can combine shares before the final compression.
    // The role mux follows the swap captured with the operation.
    always_comb begin
        lat1 = swap_q ? op_x_prev : op_y;
        prv  = swap_q ? b_q       : op_x_prev;
        ab_d = '0;
        t1_d = '0;
        t2_d = '0;
        for (int j = 0; j < N; j++) begin
            for (int i = 0; i < d; i++) begin
                ab_d[i*N+j] = lat1[i*N+j] & prv[i*N+j];
                for (int k = 0; k < d; k++) begin
                    if (k != i) begin
                        t1_d[oidx(i,k)*N+j] = ~lat1[i*N+j] & r_q[j*P+pidx(i,k)];
                        t2_d[oidx(i,k)*N+j] =  lat1[i*N+j] & u_q[oidx(i,k)*N+j];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ab_q <= '0;
            t1_q <= '0;
            t2_q <= '0;
        end else if (v1_q) begin
            ab_q <= ab_d;
            t1_q <= t1_d;
            t2_q <= t2_d;
        end
    end

    // Output: per-share compression of registered terms only
    always_comb begin
        res = '0;
        for (int j = 0; j < N; j++) begin
            for (int i = 0; i < d; i++) begin
                res[i*N+j] = ab_q[i*N+j];
                for (int k = 0; k < d; k++) begin
                    if (k != i) begin
                        res[i*N+j] = res[i*N+j] ^ t1_q[oidx(i,k)*N+j] ^ t2_q[oidx(i,k)*N+j];
                    end
                end
            end
        end
    end

`ifdef MSKAND_HPC2_ARRAY_OUT_GATE_EN
    assign out = v2_q ? res : '0;
`else
    assign out = res;
`endif

    assign out_valid = v2_q;
    assign busy      = v1_q | v2_q;

endmodule
